// File: rtl/ibuf_feed_pkg.sv
// Shared types and defaults for the systolic-array input feeder (ibuf_feed).
// The optional drain phase is enabled by defining IBUF_DRAIN_EN.
package ibuf_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned IBUF_AW    = 8;
  localparam int unsigned IBUF_DW    = 16;
  localparam int unsigned IBUF_DRAIN = 8;

endpackage

// File: rtl/ibuf_feed_1r1w.sv
// ibuf_1r1w: 2^AW x DW simple dual-port RAM, synchronous read, 1-cycle latency.
// A same-cycle read and write to one address returns the old data.
module ibuf_1r1w
  import ibuf_feed_pkg::*;
#(
  parameter int unsigned AW = IBUF_AW,
  parameter int unsigned DW = IBUF_DW
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1 << AW)-1];

  always_ff @(posedge clk) begin
    if (wen) mem[wadr] <= wdata;
    if (ren) rdata <= mem[radr];
  end

endmodule

// File: rtl/ibuf_feed.sv
// ibuf_feed: streams run_cntr words from a CPU-loaded operand buffer into the
// systolic array over valid/ready. Define IBUF_DRAIN_EN to append DRAIN zero words.
module ibuf_feed
  import ibuf_feed_pkg::*;
#(
  parameter int unsigned AW    = IBUF_AW,
  parameter int unsigned DW    = IBUF_DW,
  parameter int unsigned DRAIN = IBUF_DRAIN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] sbus_wadr,
  input  logic [DW-1:0] sbus_wdata,
  input  logic          sbus_wen,
  input  logic [AW:0]   run_cntr,
  input  logic          start,
  input  logic          s_ready,
  output logic [DW-1:0] s_in,
  output logic          s_valid,
  output logic          s_last,
  output logic          s_running,
  output logic          finish
);

  state_t        state;
  logic [AW:0]   rem_issue;
  logic [AW-1:0] rd_adr;
  logic          inflight;
  logic [1:0]    occ;
  logic [DW-1:0] d0, d1;
  logic [DW-1:0] rdata;
  logic [DW-1:0] head;
  logic [2:0]    pend;
  logic          issue, pop, stream_valid, final_data;

`ifdef IBUF_DRAIN_EN
  localparam int unsigned DCW = $clog2(DRAIN + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN - 1);
  logic [DCW-1:0] drain_cnt;
`endif

  ibuf_1r1w #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .wen   (sbus_wen),
    .wadr  (sbus_wadr),
    .wdata (sbus_wdata),
    .ren   (issue),
    .radr  (rd_adr),
    .rdata (rdata)
  );

  // The RAM output register acts as a bypass stage in front of the skid FIFO,
  // so a word is presentable in the cycle its read data returns.
  always_comb begin
    head = '0;
    if (occ != 2'd0)  head = d0;
    else if (inflight) head = rdata;
  end

  assign pend         = {1'b0, occ} + {2'b0, inflight};
  assign stream_valid = (state == ST_STREAM) && (pend != 3'd0);
  assign final_data   = (state == ST_STREAM) && (rem_issue == '0) && (pend == 3'd1);
  assign pop          = s_valid & s_ready;
  assign issue        = (state == ST_STREAM) && !start && (rem_issue != '0) &&
                        (pend < 3'd2 + {2'b0, pop});

`ifdef IBUF_DRAIN_EN
  assign s_valid = stream_valid | (state == ST_DRAIN);
  assign s_in    = (state == ST_DRAIN) ? '0 : head;
  assign s_last  = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
`else
  assign s_valid = stream_valid;
  assign s_in    = head;
  assign s_last  = final_data;
`endif

  assign s_running = (state == ST_STREAM) || (state == ST_DRAIN);
  assign finish    = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rem_issue <= '0;
      rd_adr    <= '0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      d0        <= '0;
      d1        <= '0;
`ifdef IBUF_DRAIN_EN
      drain_cnt <= '0;
`endif
    end else if (start) begin
      rem_issue <= run_cntr;
      rd_adr    <= '0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
`ifdef IBUF_DRAIN_EN
      drain_cnt <= '0;
      state     <= (run_cntr != '0) ? ST_STREAM : ST_DRAIN;
`else
      state     <= (run_cntr != '0) ? ST_STREAM : ST_DONE;
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_adr    <= rd_adr + 1'b1;
        rem_issue <= rem_issue - 1'b1;
      end
      if (state == ST_STREAM) begin
        case ({inflight, pop})
          2'b10: begin
            if (occ == 2'd0) d0 <= rdata;
            else             d1 <= rdata;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            d0  <= d1;
            occ <= occ - 2'd1;
          end
          // With occ == 0 the arriving word is the one popped via the bypass.
          2'b11: begin
            if (occ == 2'd2) begin
              d0 <= d1;
              d1 <= rdata;
            end else if (occ == 2'd1) begin
              d0 <= rdata;
            end
          end
          default: ;
        endcase
      end
      case (state)
        ST_STREAM: begin
          if (pop && final_data) begin
`ifdef IBUF_DRAIN_EN
            state <= ST_DRAIN;
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef IBUF_DRAIN_EN
        ST_DRAIN: begin
          if (pop) begin
            if (drain_cnt == DRAIN_LAST) begin
              drain_cnt <= '0;
              state     <= ST_DONE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ibuf_feed.sv
// Scoreboard bench for ibuf_feed: a negedge monitor checks every handshake and
// status output against a queue-based model of the expected word stream.
module tb_ibuf_feed;

  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int DRAIN_N = 8;
`ifdef IBUF_DRAIN_EN
  localparam bit DRAIN_ON = 1'b1;
`else
  localparam bit DRAIN_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] sbus_wadr = '0;
  logic [DW-1:0] sbus_wdata = '0;
  logic          sbus_wen = 1'b0;
  logic [AW:0]   run_cntr = '0;
  logic          start = 1'b0;
  logic          s_ready = 1'b0;
  logic [DW-1:0] s_in;
  logic          s_valid, s_last, s_running, finish;

  ibuf_feed #(.AW(AW), .DW(DW), .DRAIN(DRAIN_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sbus_wadr  (sbus_wadr),
    .sbus_wdata (sbus_wdata),
    .sbus_wen   (sbus_wen),
    .run_cntr   (run_cntr),
    .start      (start),
    .s_ready    (s_ready),
    .s_in       (s_in),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_running  (s_running),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            adr;
    bit            drain;
    bit            last;
  } exp_t;

  typedef struct {
    int cyc;
    int adr;
    int dat;
  } wr_t;

  exp_t          q[$];
  wr_t           wr_sched[$];
  logic [DW-1:0] mem_m [256];
  int            checks = 0;
  int            failures = 0;
  bit            strict = 1'b0;
  bit            exp_run = 1'b0;
  bit            exp_fin = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_in = '0;
  int            since = 1000;
  int            run_len = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_run = 1'b0;
        exp_fin = 1'b0;
        prev_hold = 1'b0;
        since = 1000;
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_s_last", 32'(s_last), 0);
        chk("rst_s_running", 32'(s_running), 0);
        chk("rst_finish", 32'(finish), 0);
        chk("rst_s_in", 32'(s_in), 0);
      end else begin
        chk("finish", 32'(finish), 32'(exp_fin));
        chk("s_running", 32'(s_running), 32'(exp_run));
        if (q.size() == 0 || (since == 1 && run_len > 0))
          chk("valid_quiet", 32'(s_valid), 0);
        else if (strict)
          chk("valid_nobubble", 32'(s_valid), 1);
        if (prev_hold) begin
          chk("hold_valid", 32'(s_valid), 1);
          chk("hold_data", 32'(s_in), 32'(prev_in));
        end
        exp_fin = 1'b0;
        if (s_valid && s_ready) begin
          if (q.size() == 0) begin
            chk("pop_unexpected", 32'(s_in), 32'hDEAD_0000);
          end else begin
            e = q.pop_front();
            chk(e.drain ? "drain_data" : "data", 32'(s_in), 32'(e.data));
            chk("s_last", 32'(s_last), 32'(e.last));
            if (e.last) begin
              exp_fin = 1'b1;
              exp_run = 1'b0;
            end
          end
        end
        prev_hold = s_valid && !s_ready;
        prev_in = s_in;
        if (sbus_wen) begin
          mem_m[sbus_wadr] = sbus_wdata;
          // In a ready-held run, word a is read in cycle a+1; writes from then on are too late.
          foreach (q[i])
            if (!q[i].drain && q[i].adr == int'(sbus_wadr) && !(strict && since >= int'(sbus_wadr) + 1))
              q[i].data = sbus_wdata;
        end
        since++;
        if (start) begin
          q.delete();
          prev_hold = 1'b0;
          since = 1;
          run_len = int'(run_cntr);
          for (int i = 0; i < run_len; i++)
            q.push_back('{data: mem_m[i], adr: i, drain: 1'b0, last: (i == run_len - 1) && !DRAIN_ON});
          if (DRAIN_ON)
            for (int j = 0; j < DRAIN_N; j++)
              q.push_back('{data: '0, adr: -1, drain: 1'b1, last: (j == DRAIN_N - 1)});
          exp_fin = (q.size() == 0);
          exp_run = (q.size() != 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    sbus_wadr = 8'(a);
    sbus_wdata = 16'(d);
    sbus_wen = 1'b1;
    step();
    sbus_wen = 1'b0;
  endtask

  // pct < 0 toggles s_ready 1,0,1,0...; abort_at/rst_at = 0 disables those events.
  task automatic run(input int n, input bit str, input int pct, input int abort_at,
                     input int abort_n, input int rst_at);
    bit done;
    strict = str;
    s_ready = 1'b1;
    run_cntr = 9'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 3000 && !done; c++) begin
      if (!str) s_ready = (pct < 0) ? c[0] : ($urandom_range(0, 99) < pct);
      start = (c == abort_at);
      if (start) run_cntr = 9'(abort_n);
      rst_n = (c != rst_at);
      sbus_wen = 1'b0;
      foreach (wr_sched[i])
        if (wr_sched[i].cyc == c) begin
          sbus_wen = 1'b1;
          sbus_wadr = 8'(wr_sched[i].adr);
          sbus_wdata = 16'(wr_sched[i].dat);
        end
      step();
      done = (q.size() == 0) && !exp_run && !exp_fin && !start && rst_n;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL run_timeout: got still-busy expected idle (n=%0d) at t=%0t", n, $time);
    end
    rst_n = 1'b1;
    start = 1'b0;
    sbus_wen = 1'b0;
    s_ready = 1'b1;
    wr_sched.delete();
    step();
    step();
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Four-word run, ready held, then ready toggling
    write_word(0, 'h0011);
    write_word(1, 'h0022);
    write_word(2, 'h0033);
    write_word(3, 'h0044);
    run(4, 1'b1, 100, 0, 0, 0);
    run(4, 1'b0, -1, 0, 0, 0);

    // Empty run
    run(0, 1'b1, 100, 0, 0, 0);

    // Full-depth run, data = address, with writes before/at/after the read point
    for (int a = 0; a < 256; a++) write_word(a, a);
    wr_sched.push_back('{cyc: 20, adr: 200, dat: 'hBEEF});
    wr_sched.push_back('{cyc: 101, adr: 100, dat: 'hA100});
    wr_sched.push_back('{cyc: 150, adr: 150, dat: 'hB150});
    run(256, 1'b1, 100, 0, 0, 0);

    // Abort after word 2, restart with a fresh four-word run
    write_word(0, 'h0011);
    write_word(1, 'h0022);
    write_word(2, 'h0033);
    write_word(3, 'h0044);
    run(4, 1'b1, 100, 3, 4, 0);

    // Randomised runs: ready patterns, aborts, one mid-run reset
    for (int it = 0; it < 16; it++) begin
      int nw, n, mode, ab, rs;
      nw = $urandom_range(0, 5);
      for (int k = 0; k < nw; k++) write_word($urandom_range(0, 40), $urandom);
      n = ($urandom_range(0, 4) == 0) ? 40 : $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 3) : 0;
      rs = (it == 9) ? 4 : 0;
      run(n, mode == 0, (mode == 1) ? -1 : 70, ab, $urandom_range(1, 12), rs);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ibuf_feed.md
# ibuf_feed

Input-side feeder for the systolic array, the transmit counterpart of the output capture buffer. The CPU loads a 256×16 operand buffer over the sbus write port. A start pulse then streams `run_cntr` words, from address 0 upward, into the array over a valid/ready handshake. Progress is reported with `s_running` and a one-cycle `finish` pulse.

## Interface
Parameters:
- `AW`, 8: buffer address width; depth is 2^AW.
- `DW`, 16: data width.
- `DRAIN`, 8: number of zero flush words (used only with `IBUF_DRAIN_EN`).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sbus_wadr`  in  AW  CPU write address.
- `sbus_wdata`  in  DW  CPU write data.
- `sbus_wen`  in  1  CPU write strobe; one word per cycle.
- `run_cntr`  in  AW+1  number of words to stream, 0..256.
- `start`  in  1  one-cycle start strobe.
- `s_ready`  in  1  array accepts a word this cycle.
- `s_in`  out  DW  word to array.
- `s_valid`  out  1  `s_in` is valid.
- `s_last`  out  1  qualifies the final word of the run.
- `s_running`  out  1  a run is in progress.
- `finish`  out  1  one-cycle end-of-run pulse.

## Operation
- FSM states are IDLE, STREAM, DRAIN and DONE.
- IDLE:
  - `start` loads `rem <= run_cntr`, clears `rd_adr` and flushes the skid FIFO.
  - Goes to STREAM if `run_cntr != 0`, otherwise to DONE.
- STREAM:
  - Issues a RAM read at `rd_adr` when `rem_issue > 0` and (`occ + inflight − pop`) < 2.
  - `occ` is the 2-entry skid FIFO occupancy; `inflight` is a read issued last cycle; `pop` is `s_valid & s_ready`.
  - Each issue increments `rd_adr` (AW bits; cannot wrap within a legal run) and decrements `rem_issue`.
  - Read data lands in the FIFO one cycle after issue.
  - The FIFO head drives `s_in` and `s_valid`.
  - The state ends when the last data word is popped: goes to DRAIN if the macro is set, otherwise to DONE.
- DRAIN: presents `s_in = 0`, `s_valid = 1` for `DRAIN` accepted words, counted with a `$clog2(DRAIN+1)`-bit counter, then goes to DONE.
- DONE: asserts `finish` for exactly one cycle, then returns to IDLE.
- `s_last = s_valid` on the final word of the run: the last data word, or the last drain word when `IBUF_DRAIN_EN` is set.
- `s_running = (state == STREAM) | (state == DRAIN)`.
- `s_in` and `s_valid` are stable while `s_valid & ~s_ready`.
- `start` in any state aborts the current run: FIFO flushed, `s_valid` drops the next cycle, no `finish` for the aborted run, and the new run begins.
- CPU writes are always accepted.
  - A write to an address not yet read is streamed with the new value.
  - A read and write to the same address in the same cycle returns the old data.
- Reset mid-run: all state clears immediately and no `finish` is produced.

## Timing
- Reset values: `s_in = 0`, `s_valid = 0`, `s_last = 0`, `s_running = 0`, `finish = 0`. FSM in IDLE, counters at 0, FIFO empty.
- `start` sampled at edge 0: first read issued in cycle 1, `s_valid` high from cycle 2.
- Throughput is 1 word/cycle when `s_ready` is held high; no bubbles.
- `finish` is asserted in the cycle after the handshake of the `s_last` word.
- `run_cntr = 0`: `finish` pulses in cycle 1 and `s_valid` never rises (macro off). With the macro on, drain words are still sent.
- RAM: synchronous read, 1-cycle latency, write-first is not allowed (same-cycle read returns old data).

## Configuration
- `IBUF_DRAIN_EN` defined: after the data words, `DRAIN` zero words are streamed to flush the array's skew pipeline; `s_running` covers the DRAIN state.
- `IBUF_DRAIN_EN` undefined: the DRAIN state and its counter are absent; STREAM goes directly to DONE.

## Structure
- Shared package holds:
  - the state enum (IDLE, STREAM, DRAIN, DONE);
  - `IBUF_AW = 8`, `IBUF_DW = 16`;
  - the default `DRAIN` value.
- Sub-module `ibuf_1r1w`: 2^AW×DW simple dual-port RAM with synchronous read, shared style with the output buffer RAM.
- The skid FIFO is inline logic.

## Test plan
- Load addr 0..3 = 0x0011, 0x0022, 0x0033, 0x0044; `run_cntr = 4`; `s_ready = 1`; macro off -> these four values in cycles 2..5, `s_last` in cycle 5, `finish` in cycle 6.
- Same load, `s_ready` toggling 1,0,1,0 -> each word held stable while not ready, no duplicates or drops, order preserved.
- `run_cntr = 0` -> `finish` in cycle 1, `s_valid` stays 0, `s_running` stays 0.
- `run_cntr = 256`, data = address -> 256 words 0..255 back-to-back with no bubble, `s_last` on 255.
- Second `start` issued mid-run after word 2 -> `s_valid` drops, the new run restarts at word 0, exactly one `finish` (for the new run).
- `IBUF_DRAIN_EN`, `DRAIN = 8`, `run_cntr = 2` -> 2 data words then 8 zero words, `s_last` on the 10th word, `finish` one cycle later.
